// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and its neighbours: key pulses and
// collision flags in, game status / flash / death count out.
interface game_ctrl_if;
   logic       left_press;
   logic       right_press;
   logic       up_press;
   logic       down_press;
   logic       hitBody;
   logic       hitWall;
   logic [1:0] gameStatus;
   logic       dieFlash;
   logic [7:0] deathCount;

   modport master (
      output left_press, right_press, up_press, down_press, hitBody, hitWall,
      input  gameStatus, dieFlash, deathCount
   );

   modport slave (
      input  left_press, right_press, up_press, down_press, hitBody, hitWall,
      output gameStatus, dieFlash, deathCount
   );
endinterface

// File: rtl/game_ctrl.sv
// Snake game-state sequencer: RESTART -> START -> PLAY -> DIE -> RESTART loop,
// with the timed death flash and a saturating death counter.
module game_ctrl #(
   parameter int RESTART_CYCLES = 5,
   parameter int FLASH_HALF     = 25_000_000,
   parameter int FLASH_TOGGLES  = 8
) (
   input  logic        clk,
   input  logic        rst,
   game_ctrl_if.slave  bus
);

   localparam int RW = $clog2(RESTART_CYCLES) + 1;
   localparam int HW = $clog2(FLASH_HALF) + 1;
   localparam int EW = $clog2(FLASH_TOGGLES) + 1;

   localparam logic [RW-1:0] RESTART_LAST = RW'(RESTART_CYCLES - 1);
   localparam logic [HW-1:0] HALF_LAST    = HW'(FLASH_HALF - 1);
   localparam logic [EW-1:0] EDGE_LAST    = EW'(FLASH_TOGGLES - 1);

   typedef enum logic [1:0] {
      RESTART = 2'b00,
      START   = 2'b01,
      PLAY    = 2'b10,
      DIE     = 2'b11
   } state_t;

   state_t          state, stateNext;
   logic [RW-1:0]   restartCnt, restartCntNext;
   logic [HW-1:0]   halfCnt, halfCntNext;
   logic [EW-1:0]   edgeCnt, edgeCntNext;
   logic            dieFlash, dieFlashNext;
   logic [7:0]      deathCount, deathCountNext;
   logic            anyPress;
   logic            anyHit;

   assign anyPress = bus.left_press | bus.right_press | bus.up_press | bus.down_press;
   assign anyHit   = bus.hitBody | bus.hitWall;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RESTART;
         restartCnt <= '0;
         halfCnt    <= '0;
         edgeCnt    <= '0;
         dieFlash   <= 1'b0;
         deathCount <= '0;
      end else begin
         state      <= stateNext;
         restartCnt <= restartCntNext;
         halfCnt    <= halfCntNext;
         edgeCnt    <= edgeCntNext;
         dieFlash   <= dieFlashNext;
         deathCount <= deathCountNext;
      end
   end

   always_comb begin
      stateNext      = state;
      restartCntNext = restartCnt;
      halfCntNext    = halfCnt;
      edgeCntNext    = edgeCnt;
      dieFlashNext   = 1'b0;
      deathCountNext = deathCount;

      unique case (state)
         RESTART: begin
            // restartCnt starts at 0 on the first cycle RESTART is visible
            if (restartCnt == RESTART_LAST) begin
               stateNext      = START;
               restartCntNext = '0;
            end else begin
               restartCntNext = restartCnt + 1'b1;
            end
         end

         START: begin
            if (anyPress) stateNext = PLAY;
         end

         PLAY: begin
            // A hit takes priority over any simultaneous key press
            if (anyHit) begin
               stateNext    = DIE;
               dieFlashNext = 1'b1;
               halfCntNext  = '0;
               edgeCntNext  = '0;
               if (deathCount != 8'hFF) deathCountNext = deathCount + 8'd1;
            end
         end

         DIE: begin
            dieFlashNext = dieFlash;
            if (halfCnt == HALF_LAST) begin
               halfCntNext  = '0;
               edgeCntNext  = edgeCnt + 1'b1;
               dieFlashNext = ~dieFlash;
               // The final toggle lands the flash at 0 and hands back to RESTART
               if (edgeCnt == EDGE_LAST) begin
                  stateNext      = RESTART;
                  dieFlashNext   = 1'b0;
                  restartCntNext = '0;
               end
            end else begin
               halfCntNext = halfCnt + 1'b1;
            end
         end
      endcase
   end

   assign bus.gameStatus = state;
   assign bus.dieFlash   = dieFlash;
   assign bus.deathCount = deathCount;

endmodule
